// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: data width, ALU opcode encodings
// and arbiter FSM state encodings.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 3;

  // ALU operation encodings; 3'b101 is unassigned
  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by the arbiter.
// Flags: overflow (signed), carry_out (for SUB/SLT/SLTU this is the borrow,
// i.e. a < b unsigned), zero (result == 0). Unassigned opcodes yield 0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              carry_out,
  output logic              zero
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;
  logic            add_ovf;
  logic            sub_ovf;
  logic            slt_bit;

  // Shared adder/subtractor terms reused by several opcodes
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    add_ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum_ext[DATA_W-1] != a[DATA_W-1]);
    sub_ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (diff_ext[DATA_W-1] != a[DATA_W-1]);
    slt_bit  = diff_ext[DATA_W-1] ^ sub_ovf;
  end

  // Opcode decode and flag generation
  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD: begin
        result    = sum_ext[DATA_W-1:0];
        overflow  = add_ovf;
        carry_out = sum_ext[DATA_W];
      end
      ALU_SUB: begin
        result    = diff_ext[DATA_W-1:0];
        overflow  = sub_ovf;
        carry_out = diff_ext[DATA_W];
      end
      ALU_SLT: begin
        result    = {{(DATA_W-1){1'b0}}, slt_bit};
        overflow  = sub_ovf;
        carry_out = diff_ext[DATA_W];
      end
      ALU_SLTU: begin
        result    = {{(DATA_W-1){1'b0}}, diff_ext[DATA_W]};
        overflow  = sub_ovf;
        carry_out = diff_ext[DATA_W];
      end
      ALU_XOR: result = a ^ b;
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// One operation in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold
// result until the owner takes it). Optional per-requester completed-op
// counters are built only when ALU_ARB_PERF_EN is defined; otherwise
// grant_cnt0/1 are constant 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [FLAG_W-1:0] rsp0_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1
);

  arb_state_e                   state_reg;
  logic                         last_reg;    // requester served most recently
  logic                         owner_reg;   // requester of the op in flight
  logic [DATA_W-1:0]            a_reg;
  logic [DATA_W-1:0]            b_reg;
  logic [OP_W-1:0]              op_reg;
  logic [1:0][DATA_W-1:0]       result_reg;
  logic [1:0][FLAG_W-1:0]       flags_reg;
  logic [1:0]                   rsp_valid_reg;

  logic                         winner;
  logic                         accept;
  logic                         rsp_done;
  logic [DATA_W-1:0]            sel_a;
  logic [DATA_W-1:0]            sel_b;
  logic [OP_W-1:0]              sel_op;
  logic [DATA_W-1:0]            alu_result;
  logic                         alu_ovf;
  logic                         alu_carry;
  logic                         alu_zero;

  // Round-robin pick: on contention favour the requester not served last
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_reg;
    else if (req1_valid)          winner = 1'b1;
    sel_a  = winner ? req1_A  : req0_A;
    sel_b  = winner ? req1_B  : req0_B;
    sel_op = winner ? req1_op : req0_op;
  end

  // Ready is gated by rst_n so it drops the instant reset asserts
  assign accept     = rst_n && (state_reg == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !winner;
  assign req1_ready = accept &&  winner;
  assign rsp_done   = (state_reg == ST_RESP) && (owner_reg ? rsp1_ready : rsp0_ready);

  alu u_alu (
    .a         (a_reg),
    .b         (b_reg),
    .op        (op_reg),
    .result    (alu_result),
    .overflow  (alu_ovf),
    .carry_out (alu_carry),
    .zero      (alu_zero)
  );

  // Arbiter FSM with registered operands, results and response valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      last_reg      <= 1'b1;
      owner_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      result_reg    <= '0;
      flags_reg     <= '0;
      rsp_valid_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_reg     <= sel_a;
            b_reg     <= sel_b;
            op_reg    <= sel_op;
            owner_reg <= winner;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_reg[owner_reg]    <= alu_result;
          flags_reg[owner_reg]     <= {alu_ovf, alu_carry, alu_zero};
          rsp_valid_reg[owner_reg] <= 1'b1;
          state_reg                <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_done) begin
            rsp_valid_reg <= '0;
            last_reg      <= owner_reg;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp0_valid  = rsp_valid_reg[0];
  assign rsp1_valid  = rsp_valid_reg[1];
  assign rsp0_result = result_reg[0];
  assign rsp1_result = result_reg[1];
  assign rsp0_flags  = flags_reg[0];
  assign rsp1_flags  = flags_reg[1];

`ifdef ALU_ARB_PERF_EN
  logic [1:0][31:0] cnt_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_reg;
    // Count completed responses for this requester; wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 cnt_reg <= '0;
      else if (rsp_done && (owner_reg == 1'(gi))) cnt_reg <= cnt_reg + 32'd1;
    end
    assign cnt_vec[gi] = cnt_reg;
  end

  assign grant_cnt0 = cnt_vec[0];
  assign grant_cnt1 = cnt_vec[1];
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter. Expected counter values
// follow the ALU_ARB_PERF_EN build option.
module tb_alu_arbiter;

`ifdef ALU_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic [31:0] grant_cnt0, grant_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_A      (req0_A),
    .req0_B      (req0_B),
    .req0_op     (req0_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_flags  (rsp0_flags),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_A      (req1_A),
    .req1_B      (req1_B),
    .req1_op     (req1_op),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_flags  (rsp1_flags),
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
  );

  task automatic clear_inputs();
    req0_valid = 0; req0_A = 0; req0_B = 0; req0_op = 0; rsp0_ready = 0;
    req1_valid = 0; req1_A = 0; req1_B = 0; req1_op = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    req0_valid = 1;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
    total++; if ({rsp0_result, rsp1_result, rsp0_flags, rsp1_flags} !== 70'd0) begin bad++; $display("FAIL reset_results got=%h exp=0", {rsp0_result, rsp1_result, rsp0_flags, rsp1_flags}); end
    total++; if ({grant_cnt0, grant_cnt1} !== 64'd0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {grant_cnt0, grant_cnt1}); end
    repeat (2) @(negedge clk);
    req0_valid = 0;
    rst_n = 1;
    $display("reset: done");
  endtask

  task automatic test_add_req0();
    @(negedge clk);
    req0_valid = 1; req0_A = 32'd5; req0_B = 32'd3; req0_op = 3'b000; rsp0_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL add_ready got=%b exp=10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0; req0_A = 32'd99;  // post-handshake change must not matter
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL add_exec_valid got=%b exp=0", rsp0_valid); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL add_exec_ready got=%b exp=0", req0_ready); end
    step();
    total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL add_rsp_valid got=%b exp=1", rsp0_valid); end
    total++; if (rsp0_result !== 32'd8) begin bad++; $display("FAIL add_result got=%h exp=%h", rsp0_result, 32'd8); end
    total++; if (rsp0_flags !== 3'b000) begin bad++; $display("FAIL add_flags got=%b exp=000", rsp0_flags); end
    total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL add_rsp1_valid got=%b exp=0", rsp1_valid); end
    step();
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL add_valid_drop got=%b exp=0", rsp0_valid); end
    rsp0_ready = 0;
    $display("op req0 ADD 5+3 -> %h flags %b", rsp0_result, rsp0_flags);
  endtask

  task automatic test_sub_req1();
    @(negedge clk);
    req1_valid = 1; req1_A = 32'd3; req1_B = 32'd5; req1_op = 3'b001; rsp1_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL sub_ready got=%b exp=01", {req0_ready, req1_ready}); end
    step();
    req1_valid = 0;
    step();
    total++; if (rsp1_valid !== 1'b1) begin bad++; $display("FAIL sub_rsp_valid got=%b exp=1", rsp1_valid); end
    total++; if (rsp1_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_result got=%h exp=fffffffe", rsp1_result); end
    total++; if (rsp1_flags !== 3'b010) begin bad++; $display("FAIL sub_flags got=%b exp=010", rsp1_flags); end
    total++; if (rsp0_result !== 32'd8) begin bad++; $display("FAIL sub_rsp0_hold got=%h exp=8", rsp0_result); end
    step();
    rsp1_ready = 0;
    $display("op req1 SUB 3-5 -> %h flags %b", rsp1_result, rsp1_flags);
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res;
    do_reset();
    req0_valid = 1; req0_A = 32'd10; req0_B = 32'd4;  req0_op = 3'b000; rsp0_ready = 1;
    req1_valid = 1; req1_A = 32'hFF; req1_B = 32'h0F; req1_op = 3'b100; rsp1_ready = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        exp_res = 32'd14;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rr_grant%0d got=%b exp=10", k, {req0_ready, req1_ready}); end
      end else begin
        exp_res = 32'hF0;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL rr_grant%0d got=%b exp=01", k, {req0_ready, req1_ready}); end
      end
      step();
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rr_exec_ready%0d got=%b exp=00", k, {req0_ready, req1_ready}); end
      step();
      if (k % 2 == 0) begin
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin bad++; $display("FAIL rr_rsp_valid%0d got=%b exp=10", k, {rsp0_valid, rsp1_valid}); end
        total++; if (rsp0_result !== exp_res) begin bad++; $display("FAIL rr_result%0d got=%h exp=%h", k, rsp0_result, exp_res); end
      end else begin
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin bad++; $display("FAIL rr_rsp_valid%0d got=%b exp=01", k, {rsp0_valid, rsp1_valid}); end
        total++; if (rsp1_result !== exp_res) begin bad++; $display("FAIL rr_result%0d got=%h exp=%h", k, rsp1_result, exp_res); end
      end
      $display("op rr%0d owner=%0d result=%h", k, k % 2, exp_res);
      step();
    end
    total++; if (grant_cnt0 !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL rr_cnt0 got=%0d exp=%0d", grant_cnt0, PERF ? 2 : 0); end
    total++; if (grant_cnt1 !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL rr_cnt1 got=%0d exp=%0d", grant_cnt1, PERF ? 2 : 0); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_A = 32'h7FFF_FFFF; req0_B = 32'd1; req0_op = 3'b000; rsp0_ready = 0;
    req1_valid = 1; req1_A = 32'd3; req1_B = 32'd5; req1_op = 3'b001; rsp1_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b exp=10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 0;
    step();
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d got=%b exp=1", c, rsp0_valid); end
      total++; if ({rsp0_result, rsp0_flags} !== {32'h8000_0000, 3'b100}) begin bad++; $display("FAIL bp_hold_data%0d got=%h/%b exp=80000000/100", c, rsp0_result, rsp0_flags); end
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL bp_req1_blocked%0d got=%b exp=0", c, req1_ready); end
      step();
    end
    rsp0_ready = 1;
    step();
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp0_valid); end
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_req1_grant got=%b exp=1", req1_ready); end
    $display("op req0 ADD 7fffffff+1 held 5 cycles -> %h flags %b", rsp0_result, rsp0_flags);
    step();
    req1_valid = 0;
    step();
    total++; if (rsp1_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL bp_req1_result got=%h exp=fffffffe", rsp1_result); end
    total++; if (rsp0_result !== 32'h8000_0000) begin bad++; $display("FAIL bp_rsp0_hold got=%h exp=80000000", rsp0_result); end
    step();
    $display("op req1 SUB after backpressure -> %h", rsp1_result);
    clear_inputs();
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    req0_valid = 1; req0_A = 32'd1; req0_B = 32'd2; req0_op = 3'b000; rsp0_ready = 1;
    step();
    rst_n = 0;
    #1;
    total++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000) begin bad++; $display("FAIL rst_exec_hs got=%b exp=0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
    total++; if ({rsp0_result, rsp1_result, rsp0_flags, rsp1_flags} !== 70'd0) begin bad++; $display("FAIL rst_exec_data got=%h exp=0", {rsp0_result, rsp1_result, rsp0_flags, rsp1_flags}); end
    total++; if ({grant_cnt0, grant_cnt1} !== 64'd0) begin bad++; $display("FAIL rst_exec_cnt got=%h exp=0", {grant_cnt0, grant_cnt1}); end
    repeat (2) @(negedge clk);
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL rst_exec_no_rsp got=%b exp=0", rsp0_valid); end
    req0_A = 32'hF0; req0_B = 32'h0F; req0_op = 3'b111;
    rst_n = 1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rst_first_accept got=%b exp=1", req0_ready); end
    step();
    req0_valid = 0;
    step();
    total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL rst_and_valid got=%b exp=1", rsp0_valid); end
    total++; if ({rsp0_result, rsp0_flags} !== {32'd0, 3'b001}) begin bad++; $display("FAIL rst_and_data got=%h/%b exp=0/001", rsp0_result, rsp0_flags); end
    step();
    total++; if (grant_cnt0 !== (PERF ? 32'd1 : 32'd0)) begin bad++; $display("FAIL rst_and_cnt0 got=%0d exp=%0d", grant_cnt0, PERF ? 1 : 0); end
    $display("op req0 AND f0&0f after mid-exec reset -> %h flags %b", rsp0_result, rsp0_flags);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_add_req0();
    test_sub_req1();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
